// File: rtl/minisys_pkg.sv
// Shared types and decode helpers for the memory/IO access path.
package minisys_pkg;

  typedef enum logic [1:0] {IDLE, RD_WAIT, IO_WAIT, DONE} state_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

  // IO space is the top 1 KiB of the address map (addr[31:10] all ones).
  localparam logic [21:0] IO_REGION = '1;

  function automatic logic in_io_region(input logic [31:0] a);
    return a[31:10] == IO_REGION;
  endfunction

  function automatic size_t decode_size(input logic do_byte, input logic do_half);
    if (do_byte) return BYTE;
    if (do_half) return HALF;
    return WORD;
  endfunction

  function automatic logic is_aligned(input size_t sz, input logic [1:0] lane);
    case (sz)
      BYTE:    return 1'b1;
      HALF:    return !lane[0];
      default: return lane == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lane_steer.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module lane_steer
  import minisys_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  lane,
  input  logic [31:0] data,
  input  logic        sign_ext,
  output logic [3:0]  wen,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[7:0];
    case (lane)
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      2'd3:    byte_sel = data[31:24];
      default: byte_sel = data[7:0];
    endcase
    half_sel = lane[1] ? data[31:16] : data[15:0];

    wen     = '1;
    st_data = data;
    ld_data = data;
    case (size)
      BYTE: begin
        wen     = 4'b0001 << lane;
        st_data = {4{data[7:0]}};
        ld_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      HALF: begin
        wen     = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{data[15:0]}};
        ld_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      default: begin
        wen     = '1;
        st_data = data;
        ld_data = data;
      end
    endcase
  end

endmodule

// File: rtl/mem_io_access_unit.sv
// Responder for CPU memory/IO requests: drives data RAM and IO bus, stalls on loads and IO.
module mem_io_access_unit
  import minisys_pkg::*;
#(
  parameter int unsigned RAM_AW     = 14,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic [3:0]        mem_write,
  input  logic              io_read,
  input  logic              io_write,
  input  logic              do_byte,
  input  logic              do_half,
  input  logic              do_signed,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_wen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [9:0]        io_addr,
  output logic              io_rd,
  output logic              io_wr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
);

  state_t      state;
  size_t       sz_in, sz_q, sz_mux;
  logic [1:0]  lane_q, lane_mux;
  logic        sgn_q, sgn_mux;
  logic [31:0] din_mux, st_data, ld_data;
  logic [3:0]  st_wen;
  logic [7:0]  cnt;
  logic        req_ld, req_st, req_io, aligned_in, in_idle;
  logic        unused_addr;

  assign req_ld      = mem_read;
  assign req_st      = |mem_write;
  assign req_io      = io_read | io_write;
  assign sz_in       = decode_size(do_byte, do_half);
  assign aligned_in  = is_aligned(sz_in, addr[1:0]);
  assign in_idle     = reset && (state == IDLE);
  assign unused_addr = ^addr;

  // One steering unit serves both directions: live request fields while idle
  // (store steering), registered fields while waiting (load extraction).
  always_comb begin
    sz_mux   = sz_q;
    lane_mux = lane_q;
    sgn_mux  = sgn_q;
    din_mux  = (state == IO_WAIT) ? io_rdata : ram_rdata;
    if (state == IDLE) begin
      sz_mux   = sz_in;
      lane_mux = addr[1:0];
      sgn_mux  = do_signed;
      din_mux  = wdata;
    end
  end

  lane_steer u_steer (
    .size    (sz_mux),
    .lane    (lane_mux),
    .data    (din_mux),
    .sign_ext(sgn_mux),
    .wen     (st_wen),
    .st_data (st_data),
    .ld_data (ld_data)
  );

  assign ram_addr  = reset ? addr[RAM_AW+1:2] : '0;
  assign ram_wdata = in_idle ? st_data : '0;
  assign ram_wen   = (in_idle && req_st && !req_io && aligned_in) ? st_wen : '0;
  assign stall     = reset && ((state == IDLE && aligned_in && (req_io || (req_ld && !req_st)))
                               || state == RD_WAIT || state == IO_WAIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rdata    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      io_addr  <= '0;
      io_wdata <= '0;
      sz_q     <= WORD;
      lane_q   <= '0;
      sgn_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if ((req_io || req_st || req_ld) && !aligned_in) begin
            rdata <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (req_io) begin
            io_addr  <= addr[9:0];
            io_wdata <= st_data;
            io_rd    <= io_read;
            io_wr    <= io_write && !io_read;
            sz_q     <= sz_in;
            lane_q   <= addr[1:0];
            sgn_q    <= do_signed;
            cnt      <= '0;
            state    <= IO_WAIT;
          end else if (req_ld && !req_st) begin
            sz_q   <= sz_in;
            lane_q <= addr[1:0];
            sgn_q  <= do_signed;
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rdata <= ld_data;
          done  <= 1'b1;
          state <= DONE;
        end
        IO_WAIT: begin
          if (io_ack) begin
            if (io_rd) rdata <= ld_data;
            io_rd <= 1'b0;
            io_wr <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == 8'(IO_TIMEOUT - 1)) begin
            io_rd <= 1'b0;
            io_wr <= 1'b0;
            rdata <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_access_unit.sv
// Directed plus randomized checks of mem_io_access_unit against a byte-level reference model.
module tb_mem_io_access_unit;

  localparam int unsigned RAM_AW     = 14;
  localparam int unsigned IO_TIMEOUT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              mem_read, io_read, io_write, do_byte, do_half, do_signed;
  logic [3:0]        mem_write;
  logic [31:0]       addr, wdata, rdata;
  logic              done, stall, err;
  logic [RAM_AW-1:0] ram_addr;
  logic [3:0]        ram_wen;
  logic [31:0]       ram_wdata, ram_rdata;
  logic [9:0]        io_addr;
  logic              io_rd, io_wr, io_ack;
  logic [31:0]       io_wdata, io_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram [0:63];
  logic [7:0]  mb  [0:255];

  mem_io_access_unit #(.RAM_AW(RAM_AW), .IO_TIMEOUT(IO_TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
    .do_byte(do_byte), .do_half(do_half), .do_signed(do_signed),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall), .err(err),
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack)
  );

  always #5 clock = ~clock;

  // Behavioural synchronous RAM device.
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (ram_wen[i]) ram[ram_addr[5:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= ram[ram_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    mem_read = 1'b0; mem_write = 4'h0; io_read = 1'b0; io_write = 1'b0;
    do_byte = 1'b0; do_half = 1'b0; do_signed = 1'b0;
  endtask

  task automatic set_size(input int sz, input bit sgn);
    do_byte = (sz == 0); do_half = (sz == 1); do_signed = sgn;
  endtask

  function automatic int nbytes(input int sz);
    return 1 << sz;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input int n, input bit sgn);
    logic [31:0] mask;
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (sgn && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] exp_wen(input logic [1:0] lane, input int sz);
    return 4'(((1 << nbytes(sz)) - 1) << lane);
  endfunction

  function automatic logic [31:0] exp_st(input logic [31:0] w, input int sz);
    if (sz == 0) return {4{w[7:0]}};
    if (sz == 1) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] mem_load(input logic [31:0] a, input int sz, input bit sgn);
    logic [31:0] v = '0;
    for (int k = 0; k < nbytes(sz); k++) v = v | (32'(mb[int'(a[7:0]) + k]) << (8 * k));
    return extend(v, nbytes(sz), sgn);
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] w, input int sz, input logic [3:0] mw);
    @(negedge clock);
    clear_req(); mem_write = mw; set_size(sz, 1'b0); addr = a; wdata = w;
    #1;
    chk("st_wen", 32'(ram_wen), 32'(exp_wen(a[1:0], sz)));
    chk("st_wdata", ram_wdata, exp_st(w, sz));
    chk("st_ram_addr", 32'(ram_addr), 32'(a[15:2]));
    chk("st_stall", 32'(stall), 32'd0);
    for (int k = 0; k < nbytes(sz); k++) mb[int'(a[7:0]) + k] = w[8*k +: 8];
    @(negedge clock);
    clear_req();
    chk("st_no_done", 32'({done, err}), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] a, input int sz, input bit sgn, input bit perturb);
    logic [31:0] e;
    e = mem_load(a, sz, sgn);
    @(negedge clock);
    clear_req(); mem_read = 1'b1; set_size(sz, sgn); addr = a;
    #1;
    chk("ld_stall_accept", 32'(stall), 32'd1);
    chk("ld_ram_addr", 32'(ram_addr), 32'(a[15:2]));
    chk("ld_no_wen", 32'(ram_wen), 32'd0);
    @(negedge clock);
    chk("ld_wait", 32'({stall, done}), 32'b10);
    if (perturb) begin addr = a ^ 32'h3; do_signed = ~sgn; end
    @(negedge clock);
    chk("ld_done", 32'({stall, done, err}), 32'b010);
    chk("ld_rdata", rdata, e);
    clear_req();
    @(negedge clock);
    chk("ld_after", 32'({done, err}), 32'd0);
  endtask

  task automatic do_io(input bit rd, input logic [31:0] a, input logic [31:0] w, input int sz,
                       input bit sgn, input int ack_at, input logic [31:0] iod);
    int hi = 0;
    bit got = 0;
    bit ok_ack;
    logic [31:0] e;
    ok_ack = (ack_at >= 1) && (ack_at <= int'(IO_TIMEOUT));
    e = (ok_ack && rd) ? extend(iod >> (8 * a[1:0]), nbytes(sz), sgn) : 32'd0;
    @(negedge clock);
    clear_req(); io_read = rd; io_write = !rd; set_size(sz, sgn); addr = a; wdata = w; io_ack = 1'b0;
    #1;
    chk("io_stall_accept", 32'(stall), 32'd1);
    chk("io_strobe_accept", 32'({io_rd, io_wr}), 32'd0);
    chk("io_no_ram_wen", 32'(ram_wen), 32'd0);
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clock);
      if (c == 1) begin
        chk("io_addr", 32'(io_addr), 32'(a[9:0]));
        if (!rd) chk("io_wdata", io_wdata, exp_st(w, sz));
      end
      if (done) begin
        got = 1;
        chk("io_err", 32'(err), 32'(!ok_ack));
        chk("io_strobe_cycles", 32'(hi), 32'(ok_ack ? ack_at : int'(IO_TIMEOUT)));
        chk("io_strobe_off", 32'({io_rd, io_wr}), 32'd0);
        chk("io_stall_done", 32'(stall), 32'd0);
        if (rd || !ok_ack) chk("io_rdata", rdata, e);
        io_ack = 1'b0;
        clear_req();
      end else begin
        chk("io_wait", 32'({stall, rd ? io_wr : io_rd}), 32'b10);
        if (rd ? io_rd : io_wr) hi++;
        io_ack   = (c == ack_at);
        io_rdata = (c == ack_at) ? iod : $urandom();
      end
    end
    if (!got) chk("io_done_seen", 32'd0, 32'd1);
    @(negedge clock);
    chk("io_after", 32'({done, err}), 32'd0);
  endtask

  task automatic do_misaligned(input int kind, input logic [31:0] a, input int sz);
    @(negedge clock);
    clear_req(); set_size(sz, 1'b1); addr = a; wdata = 32'hFFFF_FFFF;
    if (kind == 0) mem_read = 1'b1;
    else if (kind == 1) mem_write = 4'hF;
    else io_read = 1'b1;
    #1;
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_wen", 32'(ram_wen), 32'd0);
    @(negedge clock);
    chk("mis_flags", 32'({done, err, io_rd, io_wr}), 32'b1100);
    chk("mis_rdata", rdata, 32'd0);
    clear_req();
    @(negedge clock);
    chk("mis_after", 32'({done, err}), 32'd0);
  endtask

  initial begin
    int op, sz;
    bit sgn;
    logic [31:0] a;

    for (int i = 0; i < 64; i++) ram[i] = '0;
    for (int i = 0; i < 256; i++) mb[i] = '0;
    reset = 1'b0; clear_req();
    mem_read = 1'b1; addr = 32'h0000_0044; wdata = 32'h1234_5678;
    io_ack = 1'b0; io_rdata = '0;
    #12;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ctrl", 32'({done, err, stall, io_rd, io_wr, ram_wen}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_io", 32'(io_addr) | io_wdata, 32'd0);
    @(negedge clock);
    clear_req(); reset = 1'b1;

    do_store(32'h0000_0006, 32'h0000_00AB, 0, 4'hF);
    do_store(32'h0000_0000, 32'h8001_1234, 2, 4'h1);
    do_load(32'h0000_0002, 1, 1'b1, 1'b0);
    do_load(32'h0000_0002, 1, 1'b0, 1'b1);
    do_load(32'h0000_0006, 0, 1'b1, 1'b1);
    do_io(1'b1, 32'hFFFF_FC10, 32'd0, 2, 1'b0, 3, 32'h0000_00C3);
    do_io(1'b0, 32'hFFFF_FC20, 32'hDEAD_BEEF, 2, 1'b0, 0, 32'd0);
    do_io(1'b1, 32'hFFFF_FC31, 32'd0, 0, 1'b1, int'(IO_TIMEOUT), 32'h0000_8500);
    do_io(1'b0, 32'hFFFF_FC42, 32'h0000_5AA5, 1, 1'b0, 1, 32'd0);
    do_load(32'h0000_0000, 2, 1'b0, 1'b0);
    do_misaligned(0, 32'h0000_0002, 2);
    do_load(32'h0000_0000, 2, 1'b0, 1'b0);
    do_misaligned(1, 32'h0000_0001, 1);
    do_misaligned(2, 32'hFFFF_FC03, 2);

    // Reset while an IO read is outstanding.
    @(negedge clock);
    clear_req(); io_read = 1'b1; set_size(2, 1'b0); addr = 32'hFFFF_FFF0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_mid_pre", 32'({io_rd, stall}), 32'b11);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_drop", 32'({io_rd, io_wr, stall}), 32'd0);
    @(negedge clock);
    clear_req(); reset = 1'b1;
    do_store(32'h0000_0010, 32'hCAFE_F00D, 2, 4'hF);
    do_load(32'h0000_0010, 2, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      op  = $urandom_range(0, 2);
      sz  = $urandom_range(0, 2);
      sgn = 1'($urandom_range(0, 1));
      if (op == 2) begin
        a = ($urandom() | 32'hFFFF_FC00) & ~(32'(nbytes(sz)) - 32'd1);
        do_io(1'($urandom_range(0, 1)), a, $urandom(), sz, sgn, $urandom_range(1, 6), $urandom());
      end else begin
        a = 32'($urandom_range(0, 255)) & ~(32'(nbytes(sz)) - 32'd1);
        if (op == 0) do_store(a, $urandom(), sz, 4'($urandom_range(1, 15)));
        else do_load(a, sz, sgn, 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_io_access_unit.md
Name: mem_io_access_unit

Overview:
Responder side of the control unit's memory/IO request signals (MemRead, MemWrite, IORead, IOWrite, Do_Byte, Do_Half, Do_signed).
- Takes the ALU address and store data for each request and drives the data RAM and the IO bus.
- Does byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
- Stalls the CPU while a load or IO access is in flight. Sits between the execute stage and the data RAM/IO peripherals.

Parameters:
RAM_AW, 14, data RAM word-address width (RAM depth 2^RAM_AW words)
IO_TIMEOUT, 15, max cycles to wait for io_ack before aborting (1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_read  in  1  load request to RAM
mem_write  in  4  store request to RAM (any bit set = store)
io_read  in  1  load request to IO
io_write  in  1  store request to IO
do_byte  in  1  byte-size access
do_half  in  1  halfword-size access (neither do_byte nor do_half = word)
do_signed  in  1  sign-extend the loaded byte/half
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rt), right-aligned
rdata  out  32  extended load result; valid when done=1
done  out  1  one-cycle pulse: load/IO access complete
stall  out  1  hold the pipeline
err  out  1  one-cycle pulse: misaligned request or IO timeout
ram_addr  out  RAM_AW  RAM word address (addr[RAM_AW+1:2])
ram_wen  out  4  RAM byte write enables
ram_wdata  out  32  lane-steered store data
ram_rdata  in  32  RAM read data, 1-cycle synchronous latency
io_addr  out  10  addr[9:0], held during an IO access
io_rd  out  1  IO read strobe, held until ack/timeout
io_wr  out  1  IO write strobe, held until ack/timeout
io_wdata  out  32  lane-steered IO store data
io_rdata  in  32  IO read data, sampled with io_ack
io_ack  in  1  IO completion

Behaviour:
- Reset (async, reset=0): state IDLE. rdata=0, done=0, err=0, ram_wen=0, io_rd=0, io_wr=0, timeout counter=0. All outputs are 0 while in reset.
- Request types: req_ld = mem_read; req_st = |mem_write; req_io = io_read|io_write. More than one type asserted at once: priority io > st > ld.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=0.
  - A misaligned request in IDLE gives an err pulse next cycle and no RAM/IO activity. The FSM goes to DONE with rdata=0.
- Store lane steering (ram_wdata and io_wdata):
  - byte: wdata[7:0] replicated x4; wen = 1<<addr[1:0].
  - half: wdata[15:0] replicated x2; wen = 4'b0011 when addr[1]=0, else 4'b1100.
  - word: wen = 4'b1111.
- Load extraction: byte lane addr[1:0] or half lane addr[1], then sign-extend if do_signed, else zero-extend.
- FSM states: IDLE, RD_WAIT, IO_WAIT, DONE.
  - IDLE, RAM store: ram_wen driven combinationally in the same cycle. Single cycle, no stall, stay IDLE.
  - IDLE, RAM load: ram_addr driven, stall=1 combinationally, go to RD_WAIT.
  - IDLE, IO: register io_addr/io_wdata/size, assert io_rd or io_wr from the next cycle, stall=1, go to IO_WAIT, counter=0.
  - RD_WAIT: capture the extracted ram_rdata into rdata, go to DONE; stall=1.
  - IO_WAIT: on io_ack, capture the extracted io_rdata (reads only) into rdata, drop the strobes, go to DONE. Otherwise increment the counter. When the counter reaches IO_TIMEOUT-1 with no ack: drop the strobes, set rdata=0, err=1, go to DONE. stall=1 throughout. An io_ack in the same cycle as the timeout wins (normal completion).
  - DONE: done=1 for one cycle, stall=0, go to IDLE. Request inputs in this cycle belong to the instruction that just completed and are ignored.
- stall = (IDLE and (req_ld or req_io) and aligned) or state in {RD_WAIT, IO_WAIT}.
- The CPU holds all request inputs stable while stall=1. A change of inputs during RD_WAIT or IO_WAIT is ignored, because the operation uses values registered at acceptance.
- Load latency: RAM load gives done 2 cycles after acceptance. IO access gives done 1 cycle after the ack cycle.
- Reset mid-access: strobes drop immediately; no partial write is replayed.

Decomposition:
- Shared package (minisys_pkg):
  - FSM state enum.
  - Access-size encoding: BYTE, HALF, WORD.
  - IO region constant: addr[31:10] all ones, the same decode the control unit uses.
- One combinational sub-module, lane_steer: takes size, addr[1:0], data in and do_signed. Produces wen, store data and extracted load data. It is used for both the RAM path and the IO path.

Test Plan:
- Store byte (mem_write=4'hF, do_byte, addr=0x00000006, wdata=0x000000AB) -> ram_wen=4'b0100, ram_wdata=0xABABABAB, stall=0 throughout.
- Signed half load (addr=0x00000002, do_half, do_signed, ram_rdata=0x8001_1234) -> stall for 2 cycles, then done=1, rdata=0xFFFF8001. Repeat with do_signed=0 -> rdata=0x00008001.
- IO read with io_ack after 3 cycles, io_rdata=0x0000_00C3 -> io_rd high exactly 3 cycles, rdata=0x000000C3, done pulse, err=0.
- IO write with no ack and IO_TIMEOUT=4 -> io_wr high 4 cycles then low, err=1 and done=1 in the same cycle, rdata=0.
- Misaligned word load at addr=0x00000002 -> no ram/io activity, err=1 for one cycle, done=1, rdata=0.
- Assert reset during IO_WAIT -> io_rd=0, stall=0 immediately; after release, state is IDLE and a new RAM store completes in a single cycle.
